// File: rtl/lsu_pkg.sv
// Shared LSU decode constants, FSM/size enums and small decode helpers.
package lsu_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} lsu_state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

  typedef struct packed {
    logic      is_ld;
    logic      is_st;
    lsu_size_e size;
    logic      uns;
  } lsu_dec_t;

  // Anything that is not a recognised load/store comes back with both flags low.
  function automatic lsu_dec_t lsu_decode(input logic [31:0] inst);
    lsu_dec_t d;
    d.is_ld = 1'b0;
    d.is_st = 1'b0;
    d.size  = SZ_W;
    d.uns   = 1'b0;
    case (inst[6:0])
      OP_LOAD: begin
        case (inst[14:12])
          F3_B:  begin d.is_ld = 1'b1; d.size = SZ_B; end
          F3_H:  begin d.is_ld = 1'b1; d.size = SZ_H; end
          F3_W:  begin d.is_ld = 1'b1; d.size = SZ_W; end
          F3_BU: begin d.is_ld = 1'b1; d.size = SZ_B; d.uns = 1'b1; end
          F3_HU: begin d.is_ld = 1'b1; d.size = SZ_H; d.uns = 1'b1; end
          default: ;
        endcase
      end
      OP_STORE: begin
        case (inst[14:12])
          F3_B: begin d.is_st = 1'b1; d.size = SZ_B; end
          F3_H: begin d.is_st = 1'b1; d.size = SZ_H; end
          F3_W: begin d.is_st = 1'b1; d.size = SZ_W; end
          default: ;
        endcase
      end
      default: ;
    endcase
    return d;
  endfunction

  // Byte enables: loads always fetch the full word.
  function automatic logic [3:0] lsu_mask(input lsu_dec_t d, input logic [1:0] lo);
    logic [3:0] m;
    m = 4'b1111;
    if (d.is_st) begin
      case (d.size)
        SZ_B:    m = 4'b0001 << lo;
        SZ_H:    m = 4'b0011 << {lo[1], 1'b0};
        default: m = 4'b1111;
      endcase
    end
    return m;
  endfunction

  function automatic logic lsu_misaligned(input lsu_dec_t d, input logic [1:0] lo);
    logic mis;
    case (d.size)
      SZ_H:    mis = lo[0];
      SZ_W:    mis = (lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword lane out of a load word and extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_lo,
  input  lsu_size_e   i_size,
  input  logic        i_uns,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select then sign/zero extension by access size.
  always_comb begin
    case (i_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      SZ_B:    o_data = i_uns ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_H:    o_data = i_uns ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM pipeline stage: non-memory ops pass through in one cycle, loads/stores
// run an IDLE->REQ->(WAIT)->DONE handshake with a bus-error timeout.
// Optional: define LSU_MISALIGN_TRAP_EN to turn misaligned halfword/word
// accesses into an immediate error passthrough instead of a bus access.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result,
  input  logic [31:0] rd2,
  input  logic [31:0] inst,
  output logic        stall,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_mask,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] wb_data,
  output logic [31:0] wb_inst,
  output logic        wb_err
);

  localparam int TW = $clog2(MAX_WAIT + 1);

  lsu_state_e    r_state, w_next;
  logic [TW-1:0] r_tmo;
  logic [31:0]   r_addr, r_wdata, r_ldata;
  logic [3:0]    r_mask;
  logic          r_we, r_uns, r_err;
  logic [1:0]    r_lo;
  lsu_size_e     r_size;

  lsu_dec_t      w_dec;
  logic          w_mem, w_misal, w_tmo_hit;
  logic          w_start, w_cap_ld, w_set_err, w_wb_en, w_wb_err;
  logic [31:0]   w_wb_data, w_ld_data, w_st_data;

  assign w_dec     = lsu_decode(inst);
  assign w_mem     = w_dec.is_ld | w_dec.is_st;
  assign w_tmo_hit = (r_tmo == TW'(MAX_WAIT - 1));

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misal = w_mem & lsu_misaligned(w_dec, alu_result[1:0]);
`else
  assign w_misal = 1'b0;
`endif

  assign w_st_data = (w_dec.size == SZ_B) ? {4{rd2[7:0]}} :
                     (w_dec.size == SZ_H) ? {2{rd2[15:0]}} : rd2;

  lsu_load_align u_align (
    .i_rdata (rsp_rdata),
    .i_lo    (r_lo),
    .i_size  (r_size),
    .i_uns   (r_uns),
    .o_data  (w_ld_data)
  );

  assign req_addr  = r_addr;
  assign req_wdata = r_wdata;
  assign req_mask  = r_mask;
  assign req_we    = r_we;

  // Next-state and stage outputs; nothing is presented while rst is high.
  always_comb begin
    w_next    = r_state;
    stall     = 1'b0;
    req_valid = 1'b0;
    w_start   = 1'b0;
    w_cap_ld  = 1'b0;
    w_set_err = 1'b0;
    w_wb_en   = 1'b0;
    w_wb_err  = 1'b0;
    w_wb_data = alu_result;
    case (r_state)
      S_IDLE: begin
        if (w_mem && !w_misal) begin
          stall   = 1'b1;
          w_start = 1'b1;
          w_next  = S_REQ;
        end else begin
          w_wb_en  = 1'b1;
          w_wb_err = w_misal;
        end
      end
      S_REQ: begin
        stall     = 1'b1;
        req_valid = 1'b1;
        // rsp_valid is deliberately not looked at here.
        if (req_ready)      w_next = r_we ? S_DONE : S_WAIT;
        else if (w_tmo_hit) begin w_next = S_DONE; w_set_err = 1'b1; end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (rsp_valid)      begin w_next = S_DONE; w_cap_ld  = 1'b1; end
        else if (w_tmo_hit) begin w_next = S_DONE; w_set_err = 1'b1; end
      end
      S_DONE: begin
        // Go straight back to IDLE; the held instruction retires this edge.
        w_wb_en   = 1'b1;
        w_wb_err  = r_err;
        w_wb_data = (!r_we && !r_err) ? r_ldata : alu_result;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (rst) begin
      stall     = 1'b0;
      req_valid = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Timeout counter: runs only while an access is outstanding.
  always_ff @(posedge clk) begin
    if (rst)                                      r_tmo <= '0;
    else if (r_state == S_REQ || r_state == S_WAIT) r_tmo <= r_tmo + 1'b1;
    else                                          r_tmo <= '0;
  end

  // Access capture at launch, load data capture and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_mask  <= '0;
      r_we    <= 1'b0;
      r_lo    <= '0;
      r_size  <= SZ_W;
      r_uns   <= 1'b0;
      r_ldata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr  <= {alu_result[31:2], 2'b00};
        r_wdata <= w_st_data;
        r_mask  <= lsu_mask(w_dec, alu_result[1:0]);
        r_we    <= w_dec.is_st;
        r_lo    <= alu_result[1:0];
        r_size  <= w_dec.size;
        r_uns   <= w_dec.uns;
        r_err   <= 1'b0;
      end
      if (w_cap_ld)  r_ldata <= w_ld_data;
      if (w_set_err) r_err   <= 1'b1;
    end
  end

  // MEM/WB registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_data <= '0;
      wb_inst <= '0;
      wb_err  <= 1'b0;
    end else if (w_wb_en) begin
      wb_data <= w_wb_data;
      wb_inst <= inst;
      wb_err  <= w_wb_err;
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: directed ops push expected WB results
// and bus requests; a monitor checks them as the DUT presents them.
module tb_lsu_mem_stage;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LB   = 32'h00010083;
  localparam logic [31:0] I_LH   = 32'h00011083;
  localparam logic [31:0] I_LW   = 32'h00012083;
  localparam logic [31:0] I_LD   = 32'h00013083;
  localparam logic [31:0] I_LBU  = 32'h00014083;
  localparam logic [31:0] I_LHU  = 32'h00015083;
  localparam logic [31:0] I_SB   = 32'h00310023;
  localparam logic [31:0] I_SH   = 32'h00311023;
  localparam logic [31:0] I_SW   = 32'h00312023;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result, rd2, inst;
  logic        stall, req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_mask;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [31:0] wb_data, wb_inst;
  logic        wb_err;

  typedef struct {logic [31:0] data; logic [31:0] inst; logic err;} wb_t;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] mask;} rq_t;

  wb_t q_wb[$];
  rq_t q_req[$];
  int  total = 0, bad = 0, vld_cycles = 0;
  int  cfg_rdy_dly = 0, cfg_rsp_dly = 0;
  logic [31:0] cfg_rdata = 32'h0;

  always #5 clk = ~clk;

  lsu_mem_stage #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .alu_result(alu_result), .rd2(rd2), .inst(inst),
    .stall(stall), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .wb_data(wb_data), .wb_inst(wb_inst), .wb_err(wb_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_wb(input logic [31:0] d, input logic [31:0] i, input logic e);
    wb_t w;
    w.data = d; w.inst = i; w.err = e;
    q_wb.push_back(w);
  endtask

  task automatic push_req(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
    rq_t r;
    r.we = we; r.addr = a; r.wdata = wd; r.mask = m;
    q_req.push_back(r);
  endtask

  // Present an op and return once the stage releases it (stall low).
  task automatic run_op(input logic [31:0] i, input logic [31:0] a, input logic [31:0] d, output int stalls);
    int n;
    @(posedge clk); #1;
    inst = i; alu_result = a; rd2 = d;
    stalls = 0; n = 0;
    @(negedge clk); #2;
    while (stall && n < 64) begin
      stalls++; n++;
      @(negedge clk); #2;
    end
    if (n >= 64) begin
      total++; bad++;
      $display("FAIL op_timeout: inst %h still stalled after %0d cycles", i, n);
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    inst = 32'h0; alu_result = 32'h0; rd2 = 32'h0;
  endtask

  // Memory model: ready after cfg_rdy_dly valid cycles, load data cfg_rsp_dly cycles later.
  initial begin
    int vcnt, rwait;
    bit rpend;
    vcnt = 0; rwait = 0; rpend = 0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 32'h0;
    forever begin
      @(negedge clk);
      rsp_rdata = cfg_rdata;
      rsp_valid = 1'b0;
      if (rpend) begin
        if (rwait == 0) begin rsp_valid = 1'b1; rpend = 0; end
        else rwait--;
      end
      if (req_valid && !rst) begin
        req_ready = (vcnt == cfg_rdy_dly);
        vcnt++;
        if (req_ready && !req_we) begin rpend = 1; rwait = cfg_rsp_dly; end
      end else begin
        req_ready = 1'b0;
        vcnt = 0;
      end
    end
  end

  // Monitor: checks every request cycle and every retiring non-bubble op.
  initial begin
    wb_t e;
    forever begin
      @(negedge clk); #2;
      if (!rst && req_valid) begin
        vld_cycles++;
        if (q_req.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_req: addr %h with no request expected", req_addr);
        end else begin
          chk("req_addr", req_addr, q_req[0].addr);
          chk("req_we", {31'b0, req_we}, {31'b0, q_req[0].we});
          chk("req_mask", {28'b0, req_mask}, {28'b0, q_req[0].mask});
          if (q_req[0].we) chk("req_wdata", req_wdata, q_req[0].wdata);
          if (req_ready) void'(q_req.pop_front());
        end
      end
      if (!rst && !stall && inst != 32'h0) begin
        @(posedge clk); #1;
        if (q_wb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_wb: wb_inst %h with nothing expected", wb_inst);
        end else begin
          e = q_wb.pop_front();
          chk("wb_data", wb_data, e.data);
          chk("wb_inst", wb_inst, e.inst);
          chk("wb_err", {31'b0, wb_err}, {31'b0, e.err});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s, n;
    rst = 1'b1; inst = 32'h0; alu_result = 32'h0; rd2 = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #2;
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_wb_inst", wb_inst, 32'h0);
    chk("rst_wb_err", {31'b0, wb_err}, 32'h0);
    chk("rst_req_valid", {31'b0, req_valid}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);

    // Non-memory op: single-cycle passthrough.
    push_wb(32'h55, I_ADDI, 1'b0);
    run_op(I_ADDI, 32'h55, 32'h0, s);
    chk("alu_stalls", s, 0);

    // SW with ready after two cycles: request held three cycles.
    cfg_rdy_dly = 2; vld_cycles = 0;
    push_req(1'b1, 32'h100, 32'hDEADBEEF, 4'b1111);
    push_wb(32'h100, I_SW, 1'b0);
    run_op(I_SW, 32'h100, 32'hDEADBEEF, s);
    chk("sw_stalls", s, 4);
    chk("sw_vld_cycles", vld_cycles, 3);
    chk("sw_done_vld", {31'b0, req_valid}, 32'h0);

    // Byte loads from lane 3.
    cfg_rdy_dly = 0; cfg_rsp_dly = 1; cfg_rdata = 32'h80000000;
    push_req(1'b0, 32'h200, 32'h0, 4'b1111);
    push_wb(32'hFFFFFF80, I_LB, 1'b0);
    run_op(I_LB, 32'h203, 32'h0, s);
    push_req(1'b0, 32'h200, 32'h0, 4'b1111);
    push_wb(32'h00000080, I_LBU, 1'b0);
    run_op(I_LBU, 32'h203, 32'h0, s);

    // Sub-word stores.
    push_req(1'b1, 32'h0, 32'h12341234, 4'b1100);
    push_wb(32'h2, I_SH, 1'b0);
    run_op(I_SH, 32'h2, 32'h1234, s);
    push_req(1'b1, 32'h100, 32'hA5A5A5A5, 4'b0010);
    push_wb(32'h101, I_SB, 1'b0);
    run_op(I_SB, 32'h101, 32'h000000A5, s);

    // Halfword loads from the upper lane, zero extra response delay.
    cfg_rsp_dly = 0; cfg_rdata = 32'hABCD1234;
    push_req(1'b0, 32'h204, 32'h0, 4'b1111);
    push_wb(32'hFFFFABCD, I_LH, 1'b0);
    run_op(I_LH, 32'h206, 32'h0, s);
    push_req(1'b0, 32'h204, 32'h0, 4'b1111);
    push_wb(32'h0000ABCD, I_LHU, 1'b0);
    run_op(I_LHU, 32'h206, 32'h0, s);

    // Unsupported load funct3 is a plain passthrough.
    push_wb(32'h777, I_LD, 1'b0);
    run_op(I_LD, 32'h777, 32'h0, s);
    chk("ld_f3_stalls", s, 0);

    // Bus never ready: abort after MAX_WAIT request cycles.
    cfg_rdy_dly = -1; vld_cycles = 0;
    push_req(1'b0, 32'h300, 32'h0, 4'b1111);
    push_wb(32'h300, I_LW, 1'b1);
    run_op(I_LW, 32'h300, 32'h0, s);
    chk("tmo_stalls", s, 16);
    chk("tmo_vld_cycles", vld_cycles, 15);
    chk("tmo_vld_drop", {31'b0, req_valid}, 32'h0);
    q_req.delete();
    cfg_rdy_dly = 0;
    push_wb(32'h66, I_ADDI, 1'b0);
    run_op(I_ADDI, 32'h66, 32'h0, s);
    chk("tmo_back_idle", s, 0);

    // Misaligned word load.
    cfg_rdata = 32'hCAFEF00D;
`ifdef LSU_MISALIGN_TRAP_EN
    push_wb(32'h101, I_LW, 1'b1);
    run_op(I_LW, 32'h101, 32'h0, s);
    chk("mis_stalls", s, 0);
`else
    push_req(1'b0, 32'h100, 32'h0, 4'b1111);
    push_wb(32'hCAFEF00D, I_LW, 1'b0);
    run_op(I_LW, 32'h101, 32'h0, s);
`endif

    // Reset while waiting for a load response; the late response is ignored.
    cfg_rsp_dly = 4; cfg_rdata = 32'h13572468;
    push_req(1'b0, 32'h400, 32'h0, 4'b1111);
    @(posedge clk); #1;
    inst = I_LW; alu_result = 32'h400; rd2 = 32'h0;
    n = 0;
    @(negedge clk); #2;
    while (!(req_valid && req_ready) && n < 20) begin
      n++;
      @(negedge clk); #2;
    end
    chk("rstw_handshake", {31'b0, req_valid && req_ready}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1; inst = 32'h0; alu_result = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    #2;
    chk("rstw_wb_data", wb_data, 32'h0);
    chk("rstw_wb_inst", wb_inst, 32'h0);
    chk("rstw_wb_err", {31'b0, wb_err}, 32'h0);
    chk("rstw_stall", {31'b0, stall}, 32'h0);
    chk("rstw_req_valid", {31'b0, req_valid}, 32'h0);

    go_idle();
    repeat (4) @(posedge clk);
    chk("wb_queue_empty", q_wb.size(), 0);
    chk("req_queue_empty", q_req.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: cycles allowed in REQ plus WAIT before bus-error abort.
REQ-002 SHALL have port clk, input, 1: clock. All state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port alu_result, input, 32: effective address or non-memory result from the EX/MEM register.
REQ-005 SHALL have port rd2, input, 32: store data from the EX/MEM register.
REQ-006 SHALL have port inst, input, 32: instruction from the EX/MEM register. Value 0 is a bubble.
REQ-007 SHALL have port stall, output, 1: holds the EX/MEM register and upstream stages.
REQ-008 SHALL have ports req_valid (output, 1), req_ready (input, 1), req_we (output, 1), req_addr (output, 32), req_wdata (output, 32) and req_mask (output, 4): data-memory request channel.
REQ-009 SHALL have ports rsp_valid (input, 1) and rsp_rdata (input, 32): data-memory load response.
REQ-010 SHALL have ports wb_data (output, 32), wb_inst (output, 32) and wb_err (output, 1): registered MEM/WB outputs.

Function
REQ-011 SHALL decode opcode 0000011 as load, using funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-012 SHALL decode opcode 0100011 as store, using funct3 000 SB, 001 SH, 010 SW.
REQ-013 SHALL treat every other opcode or funct3 as a non-memory operation.
REQ-014 SHALL implement an FSM with states IDLE, REQ, WAIT and DONE.
REQ-015 SHALL, in IDLE with a non-memory operation, load wb_data=alu_result, wb_inst=inst and wb_err=0 on the next edge, with stall=0 (1-cycle latency).
REQ-016 SHALL, in IDLE with a memory operation, assert stall combinationally, capture address, data and mask into internal registers, and go to REQ.
REQ-017 SHALL, in REQ, drive req_valid=1 with req_addr, req_we, req_wdata and req_mask held stable until the cycle req_ready=1.
REQ-018 SHALL, on req_ready in REQ, go to DONE for a store and to WAIT for a load.
REQ-019 SHALL, on rsp_valid in WAIT, capture the aligned and extended load data and go to DONE.
REQ-020 SHALL keep req_valid=0 in IDLE, WAIT and DONE.
REQ-021 SHALL, in DONE, drive stall=0, update the wb registers (store: wb_data=alu_result) and return to IDLE; the still-present input instruction SHALL NOT restart an access.
REQ-022 SHALL assert stall in REQ and WAIT.
REQ-023 SHALL drive req_addr as {alu_result[31:2],2'b00}.
REQ-024 SHALL, for SB, drive req_wdata={4{rd2[7:0]}} and req_mask=0001<<addr[1:0].
REQ-025 SHALL, for SH, drive req_wdata={2{rd2[15:0]}} and req_mask=0011<<{addr[1],0}.
REQ-026 SHALL, for SW, drive req_wdata=rd2 and req_mask=1111.
REQ-027 SHALL drive req_mask=1111 for loads.
REQ-028 SHALL extract load data from byte lane addr[1:0] or halfword lane addr[1]; LB and LH sign-extend, LBU and LHU zero-extend.
REQ-029 SHALL count cycles spent in REQ plus WAIT with a timeout counter.
REQ-030 SHALL, when the timeout counter reaches MAX_WAIT, go to DONE with wb_err=1, wb_data=alu_result, and drop req_valid.
REQ-031 SHALL ignore rsp_valid outside WAIT.
REQ-032 SHALL, when req_ready and rsp_valid arrive in the same cycle in REQ, act on req_ready only.

Reset
REQ-033 SHALL, on rst, set FSM=IDLE and timeout counter=0, zero the captured registers, and drive wb_data=0, wb_inst=0, wb_err=0, req_valid=0 and stall=0.
REQ-034 SHALL, on rst mid-access (REQ or WAIT), abandon the access without completing it; a later rsp_valid is ignored.

Configuration
REQ-035 SHALL, with macro LSU_MISALIGN_TRAP_EN defined, flag misaligned LH/LHU/SH (addr[0]=1) and LW/SW (addr[1:0]!=0): no request, no stall, 1-cycle passthrough with wb_err=1 and wb_data=alu_result.
REQ-036 SHALL, without LSU_MISALIGN_TRAP_EN, ignore the misaligned low address bits (halfword uses lane addr[1], word uses lane 0) and issue the access normally.

Structure
REQ-037 SHALL place opcode constants, funct3 constants, the FSM state enum and the access-size enum in shared package lsu_pkg.
REQ-038 SHALL implement load lane extraction and extension in combinational sub-module lsu_load_align.

Verification
REQ-039 SHALL cover: SW addr 0x100, rd2 0xDEADBEEF, req_ready after 2 cycles -> req_mask=1111 and wdata held for 3 cycles; DONE follows; stall low in DONE; wb_data=0x100.
REQ-040 SHALL cover: LB addr 0x203, rsp_rdata 0x80000000 -> wb_data=0xFFFFFF80. Same access with LBU -> wb_data=0x00000080.
REQ-041 SHALL cover: SH addr 0x2, rd2 0x1234 -> req_mask=1100 and req_wdata=0x12341234.
REQ-042 SHALL cover: LW with req_ready never asserted, MAX_WAIT=15 -> wb_err=1 after 15 cycles, then req_valid=0 and FSM returns to IDLE.
REQ-043 SHALL cover: LW addr 0x101 -> with the macro, wb_err=1 with no req_valid; without the macro, req_addr=0x100.
REQ-044 SHALL cover: rst during WAIT, then rsp_valid -> stays IDLE, all wb outputs remain 0.
